// File: rtl/spindle_spike_gen_pkg.sv
// Shared types and constants for the spindle spike generator (optional totals: SPINDLE_SPIKE_TOTAL_EN).
package spindle_spike_gen_pkg;

    localparam int RATE_W = 17;
    localparam int CNT_W  = 8;
    localparam int SUM_W  = RATE_W + 1;

    localparam logic [31:0] FP_RATE_MAX = 32'h47C3_5000;  // 100000.0
    localparam logic [31:0] FP_ONE      = 32'h3F80_0000;  // 1.0

    localparam logic [7:0] FP_EXP_BIAS    = 8'd127;
    localparam logic [7:0] FP_EXP_SPECIAL = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        ACC,
        EMIT
    } state_t;

endpackage

// File: rtl/float_to_rate_int.sv
// Combinational IEEE-754 single to saturated unsigned rate in pps; negatives, NaN and values below 1.0 give 0.
module float_to_rate_int
    import spindle_spike_gen_pkg::*;
#(
    parameter int RATE_MAX = 100000
) (
    input  logic [31:0]       fp,
    output logic [RATE_W-1:0] rate
);

    // Any exponent at or above this gives a value >= 2**RATE_W, which is always above RATE_MAX.
    localparam logic [7:0] EXP_SAT   = 8'(127 + RATE_W);
    localparam logic [7:0] EXP_POINT = 8'd150;

    logic        sign;
    logic [7:0]  expo;
    logic [22:0] frac;
    logic [23:0] shifted;

    assign sign = fp[31];
    assign expo = fp[30:23];
    assign frac = fp[22:0];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        rate    = '0;
        shifted = {1'b1, frac} >> (EXP_POINT - expo);
        if (sign) begin
            rate = '0;
        end else if (expo == FP_EXP_SPECIAL) begin
            rate = (frac == '0) ? RATE_W'(RATE_MAX) : '0;
        end else if (expo < FP_EXP_BIAS) begin
            rate = '0;
        end else if (expo >= EXP_SAT) begin
            rate = RATE_W'(RATE_MAX);
        end else if (shifted > 24'(RATE_MAX)) begin
            rate = RATE_W'(RATE_MAX);
        end else begin
            rate = shifted[RATE_W-1:0];
        end
    end

endmodule

// File: rtl/spindle_spike_gen.sv
// Spindle afferent spike generator: per tick converts Ia/II rates, integrates them and emits spike trains.
// Define SPINDLE_SPIKE_TOTAL_EN to add running 32-bit spike totals per channel.
module spindle_spike_gen
    import spindle_spike_gen_pkg::*;
#(
    parameter int LOG2_TICKS = 10,
    parameter int RATE_MAX   = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      rate_ia,
    input  logic [31:0]      rate_ii,
    input  logic             sim_tick,
    output logic             busy,
    output logic             cnt_valid,
    output logic [CNT_W-1:0] spk_n_ia,
    output logic [CNT_W-1:0] spk_n_ii,
    output logic             spike_ia,
    output logic             spike_ii,
`ifdef SPINDLE_SPIKE_TOTAL_EN
    output logic [31:0]      total_ia,
    output logic [31:0]      total_ii,
`endif
    output logic             overrun
);

    state_t                  state;
    logic [RATE_W-1:0]       conv_ia, conv_ii;
    logic [RATE_W-1:0]       r_ia, r_ii;
    logic [LOG2_TICKS-1:0]   acc_ia, acc_ii;
    logic [SUM_W-1:0]        sum_ia, sum_ii;
    logic [CNT_W-1:0]        n_ia, n_ii, n_max;
    logic [CNT_W:0]          k, emit_last;

    float_to_rate_int #(.RATE_MAX(RATE_MAX)) u_conv_ia (.fp(rate_ia), .rate(conv_ia));
    float_to_rate_int #(.RATE_MAX(RATE_MAX)) u_conv_ii (.fp(rate_ii), .rate(conv_ii));

    always_comb begin
        sum_ia = SUM_W'(acc_ia) + SUM_W'(r_ia);
        sum_ii = SUM_W'(acc_ii) + SUM_W'(r_ii);
        n_ia   = CNT_W'(sum_ia >> LOG2_TICKS);
        n_ii   = CNT_W'(sum_ii >> LOG2_TICKS);
        n_max  = (n_ia > n_ii) ? n_ia : n_ii;
    end

    assign busy = (state != IDLE);

    // NOTE: all state here uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            r_ia      <= '0;
            r_ii      <= '0;
            acc_ia    <= '0;
            acc_ii    <= '0;
            k         <= '0;
            emit_last <= '0;
            cnt_valid <= 1'b0;
            spk_n_ia  <= '0;
            spk_n_ii  <= '0;
            spike_ia  <= 1'b0;
            spike_ii  <= 1'b0;
            overrun   <= 1'b0;
`ifdef SPINDLE_SPIKE_TOTAL_EN
            total_ia  <= '0;
            total_ii  <= '0;
`endif
        end else begin
            cnt_valid <= 1'b0;
            spike_ia  <= 1'b0;
            spike_ii  <= 1'b0;
            // A tick seen outside IDLE is dropped, including the cycle the FSM is leaving EMIT/ACC.
            if (sim_tick && state != IDLE)
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (sim_tick)
                        state <= CONV;
                end
                CONV: begin
                    r_ia  <= conv_ia;
                    r_ii  <= conv_ii;
                    state <= ACC;
                end
                ACC: begin
                    acc_ia    <= sum_ia[LOG2_TICKS-1:0];
                    acc_ii    <= sum_ii[LOG2_TICKS-1:0];
                    spk_n_ia  <= n_ia;
                    spk_n_ii  <= n_ii;
                    cnt_valid <= 1'b1;
                    k         <= '0;
                    emit_last <= {n_max, 1'b0} - (CNT_W+1)'(1);
`ifdef SPINDLE_SPIKE_TOTAL_EN
                    total_ia  <= total_ia + 32'(n_ia);
                    total_ii  <= total_ii + 32'(n_ii);
`endif
                    state     <= ((n_ia | n_ii) != '0) ? EMIT : IDLE;
                end
                EMIT: begin
                    // Even phases carry a pulse while the channel still has spikes left.
                    spike_ia <= !k[0] && (k[CNT_W:1] < spk_n_ia);
                    spike_ii <= !k[0] && (k[CNT_W:1] < spk_n_ii);
                    if (k == emit_last)
                        state <= IDLE;
                    else
                        k <= k + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spindle_spike_gen.sv
// Directed self-checking bench for spindle_spike_gen: rate integration, pulse trains, clamping, overrun, reset.
module tb_spindle_spike_gen;
    import spindle_spike_gen_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] rate_ia, rate_ii;
    logic        sim_tick;
    logic        busy, cnt_valid, spike_ia, spike_ii, overrun;
    logic [7:0]  spk_n_ia, spk_n_ii;
`ifdef SPINDLE_SPIKE_TOTAL_EN
    logic [31:0] total_ia, total_ii;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    spindle_spike_gen dut (
        .clk       (clk),
        .reset     (reset),
        .rate_ia   (rate_ia),
        .rate_ii   (rate_ii),
        .sim_tick  (sim_tick),
        .busy      (busy),
        .cnt_valid (cnt_valid),
        .spk_n_ia  (spk_n_ia),
        .spk_n_ii  (spk_n_ii),
        .spike_ia  (spike_ia),
        .spike_ii  (spike_ii),
`ifdef SPINDLE_SPIKE_TOTAL_EN
        .total_ia  (total_ia),
        .total_ii  (total_ii),
`endif
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Issues one tick and observes win negedges; index 0 is the first sample after the tick edge.
    task automatic run_tick(input int win, input int inj,
                            output int cv_n, output int cv_idx,
                            output logic [7:0] n_ia, output logic [7:0] n_ii,
                            output int p_ia, output int p_ii,
                            output int first_ia, output int first_ii,
                            output int busy_len, output int adj,
                            output logic [16:0] ria, output logic [16:0] rii);
        logic prev_ia, prev_ii;
        cv_n = 0; cv_idx = -1; n_ia = 'x; n_ii = 'x;
        p_ia = 0; p_ii = 0; first_ia = -1; first_ii = -1;
        busy_len = 0; adj = 0; ria = 'x; rii = 'x;
        prev_ia = 1'b0; prev_ii = 1'b0;
        @(negedge clk);
        sim_tick = 1'b1;
        @(negedge clk);
        sim_tick = 1'b0;
        for (int i = 0; i < win; i++) begin
            if (i > 0) @(negedge clk);
            if (busy) busy_len++;
            if (cnt_valid) begin
                cv_n++;
                cv_idx = i;
                n_ia = spk_n_ia;
                n_ii = spk_n_ii;
            end
            if (spike_ia) begin
                p_ia++;
                if (first_ia < 0) first_ia = i;
                if (prev_ia) adj++;
            end
            if (spike_ii) begin
                p_ii++;
                if (first_ii < 0) first_ii = i;
                if (prev_ii) adj++;
            end
            prev_ia = spike_ia;
            prev_ii = spike_ii;
            if (i == 1) begin
                ria = dut.r_ia;
                rii = dut.r_ii;
            end
            sim_tick = (i == inj);
        end
        sim_tick = 1'b0;
    endtask

    int          cv_n, cv_idx, p_ia, p_ii, f_ia, f_ii, blen, adj;
    logic [7:0]  n_ia, n_ii;
    logic [16:0] ria, rii;
    logic [31:0] conv_in  [12];
    int          conv_exp [12];
    int          t2_exp   [4];

    initial begin
        reset = 1'b1; sim_tick = 1'b0; rate_ia = '0; rate_ii = '0;
        conv_in  = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, FP_ONE,
                     32'h3FC0_0000, 32'h3F40_0000, 32'h0000_0001, 32'h8000_0000,
                     32'h477F_FF00, 32'h4480_1800, FP_RATE_MAX, 32'h5015_02F9};
        conv_exp = '{100000, 0, 0, 1, 1, 0, 0, 0, 65535, 1024, 100000, 100000};
        t2_exp   = '{0, 1, 0, 1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_cnt_valid", cnt_valid, 0);
        check("rst_spk_n_ia", spk_n_ia, 0);
        check("rst_spk_n_ii", spk_n_ii, 0);
        check("rst_spikes", {spike_ia, spike_ii}, 0);
        check("rst_overrun", overrun, 0);
        reset = 1'b0;

        // 1024 pps: one Ia spike every tick, accumulator stays at 0
        rate_ia = 32'h4480_0000; rate_ii = '0;
        for (int t = 0; t < 3; t++) begin
            run_tick(8, -1, cv_n, cv_idx, n_ia, n_ii, p_ia, p_ii, f_ia, f_ii, blen, adj, ria, rii);
            check("t1_cv_idx", cv_idx, 2);
            check("t1_cv_n", cv_n, 1);
            check("t1_spk_n_ia", n_ia, 1);
            check("t1_spk_n_ii", n_ii, 0);
            check("t1_pulses_ia", p_ia, 1);
            check("t1_pulses_ii", p_ii, 0);
            check("t1_first_ia", f_ia, 3);
            check("t1_busy_len", blen, 4);
            check("t1_acc_ia", dut.acc_ia, 0);
            check("t1_hold_spk_n_ia", spk_n_ia, 1);
        end

        // 512 pps on II: a spike every second tick
        do_reset();
        rate_ia = '0; rate_ii = 32'h4400_0000;
        for (int t = 0; t < 4; t++) begin
            run_tick(8, -1, cv_n, cv_idx, n_ia, n_ii, p_ia, p_ii, f_ia, f_ii, blen, adj, ria, rii);
            check("t2_spk_n_ii", n_ii, t2_exp[t]);
            check("t2_spk_n_ia", n_ia, 0);
            check("t2_pulses_ii", p_ii, t2_exp[t]);
            check("t2_busy_len", blen, 2 + 2 * t2_exp[t]);
        end

        // 200000 pps clamps to 100000; extra tick injected during EMIT is dropped
        do_reset();
        rate_ia = 32'h4843_5000; rate_ii = '0;
        run_tick(210, 50, cv_n, cv_idx, n_ia, n_ii, p_ia, p_ii, f_ia, f_ii, blen, adj, ria, rii);
        check("t3_r_ia", ria, 100000);
        check("t3_spk_n_ia", n_ia, 97);
        check("t3_acc_ia", dut.acc_ia, 672);
        check("t3_pulses_ia", p_ia, 97);
        check("t3_first_ia", f_ia, 3);
        check("t3_adjacent", adj, 0);
        check("t3_busy_len", blen, 196);
        check("t3_cv_n", cv_n, 1);
        check("t5_overrun", overrun, 1);
        run_tick(210, -1, cv_n, cv_idx, n_ia, n_ii, p_ia, p_ii, f_ia, f_ii, blen, adj, ria, rii);
        check("t5_next_spk_n_ia", n_ia, 98);
        check("t5_next_acc_ia", dut.acc_ia, 320);
        check("t5_next_pulses_ia", p_ia, 98);
        check("t5_overrun_sticky", overrun, 1);
        do_reset();
        check("t5_overrun_cleared", overrun, 0);

        // Negative and NaN rates: no spikes, ACC goes straight back to IDLE
        rate_ia = 32'hBF80_0000; rate_ii = 32'h7FC0_0000;
        run_tick(8, -1, cv_n, cv_idx, n_ia, n_ii, p_ia, p_ii, f_ia, f_ii, blen, adj, ria, rii);
        check("t4_cv_idx", cv_idx, 2);
        check("t4_spk_n_ia", n_ia, 0);
        check("t4_spk_n_ii", n_ii, 0);
        check("t4_pulses", p_ia + p_ii, 0);
        check("t4_busy_len", blen, 2);

        // Float conversion boundaries
        rate_ii = FP_ONE;
        for (int c = 0; c < 12; c++) begin
            rate_ia = conv_in[c];
            run_tick(210, -1, cv_n, cv_idx, n_ia, n_ii, p_ia, p_ii, f_ia, f_ii, blen, adj, ria, rii);
            check($sformatf("conv_%0d_r_ia", c), ria, conv_exp[c]);
            check($sformatf("conv_%0d_r_ii", c), rii, 1);
        end

        // Reset in the middle of EMIT
        do_reset();
        rate_ia = 32'h4843_5000; rate_ii = 32'h4843_5000;
        @(negedge clk);
        sim_tick = 1'b1;
        @(negedge clk);
        sim_tick = 1'b0;
        repeat (20) @(negedge clk);
        check("t6_busy_before", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("t6_spike_ia", spike_ia, 0);
        check("t6_spike_ii", spike_ii, 0);
        check("t6_busy", busy, 0);
        check("t6_spk_n_ia", spk_n_ia, 0);
        check("t6_spk_n_ii", spk_n_ii, 0);
        check("t6_acc_ia", dut.acc_ia, 0);
        reset = 1'b0;
        rate_ia = 32'h4480_0000; rate_ii = '0;
        run_tick(8, -1, cv_n, cv_idx, n_ia, n_ii, p_ia, p_ii, f_ia, f_ii, blen, adj, ria, rii);
        check("t6_after_spk_n_ia", n_ia, 1);
        check("t6_after_acc_ia", dut.acc_ia, 0);
        check("t6_after_pulses_ia", p_ia, 1);
`ifdef SPINDLE_SPIKE_TOTAL_EN
        check("t6_total_ia", total_ia, 1);
        check("t6_total_ii", total_ii, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
